// File: rtl/scsi_io_arbiter_pkg.sv
// Shared types and helpers for the scsi io-port arbiter.
package scsi_io_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    // Next target index after idx, wrapping at n.
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
        return (int'(idx) >= n - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/scsi_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or after ptr, wrapping.
module scsi_rr_pick #(
    parameter int N_TGT = 2
) (
    input  logic [N_TGT-1:0] req,
    input  logic [2:0]       ptr,
    output logic             valid,
    output logic [2:0]       idx
);

    logic [2*N_TGT-1:0] dbl;
    logic [2*N_TGT-1:0] rot;

    assign dbl = {req, req};
    assign rot = dbl >> ptr;

    always_comb begin
        logic [3:0] pos;
        valid = 1'b0;
        idx   = 3'd0;
        pos   = 4'd0;
        for (int k = 0; k < N_TGT; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(N_TGT)) pos = pos - 4'(N_TGT);
            if (!valid && rot[k]) begin
                valid = 1'b1;
                idx   = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/scsi_io_arbiter.sv
// Shares one io-controller sector port between N_TGT scsi targets, round-robin,
// routing ack and sector-buffer traffic to the granted target only.
module scsi_io_arbiter
    import scsi_io_arbiter_pkg::*;
#(
    parameter int N_TGT   = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_TGT-1:0]    tgt_rd,
    input  logic [N_TGT-1:0]    tgt_wr,
    input  logic [32*N_TGT-1:0] tgt_lba,
    output logic [N_TGT-1:0]    tgt_ack,
    input  logic [8*N_TGT-1:0]  tgt_buff_din,
    output logic [N_TGT-1:0]    tgt_buff_wr,
    output logic [31:0]         io_lba,
    output logic                io_rd,
    output logic                io_wr,
    input  logic                io_ack,
    output logic [2:0]          io_sel,
    input  logic                sd_buff_wr,
    output logic [7:0]          sd_buff_din,
    output logic                timeout_err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state, state_n;
    logic [2:0]    gnt, gnt_n;
    logic [2:0]    ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rd_n, wr_n, terr_n;
    logic [31:0]   lba_n;

    logic          pick_valid;
    logic [2:0]    pick_idx;
    logic          pick_rd;
    logic          pick_dir;
    logic [31:0]   pick_lba;
    logic          route_on;

    scsi_rr_pick #(.N_TGT(N_TGT)) u_pick (
        .req   (tgt_rd | tgt_wr),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_rd  = 1'b0;
        pick_lba = '0;
        for (int k = 0; k < N_TGT; k++) begin
            if (pick_idx == 3'(k)) begin
                pick_rd  = tgt_rd[k];
                pick_lba = tgt_lba[32*k +: 32];
            end
        end
        pick_dir = pick_rd ? DIR_RD : DIR_WR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            gnt         <= 3'd0;
            ptr         <= 3'd0;
            cnt         <= '0;
            io_rd       <= 1'b0;
            io_wr       <= 1'b0;
            io_lba      <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            io_rd       <= rd_n;
            io_wr       <= wr_n;
            io_lba      <= lba_n;
            timeout_err <= terr_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        cnt_n   = cnt;
        rd_n    = io_rd;
        wr_n    = io_wr;
        lba_n   = io_lba;
        terr_n  = 1'b0;
        case (state)
            // A stale io_ack from an abandoned transfer must drain before a new grant.
            ST_IDLE: begin
                if (!io_ack && pick_valid) begin
                    gnt_n   = pick_idx;
                    lba_n   = pick_lba;
                    rd_n    = (pick_dir == DIR_RD);
                    wr_n    = (pick_dir == DIR_WR);
                    cnt_n   = '0;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (io_ack) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = ST_BUSY;
                end else if (TIMEOUT > 0 && cnt == CNT_LAST) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    terr_n  = 1'b1;
                    ptr_n   = wrap_inc(gnt, N_TGT);
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_BUSY: begin
                if (!io_ack) state_n = ST_DONE;
            end
            ST_DONE: begin
                ptr_n   = wrap_inc(gnt, N_TGT);
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign io_sel   = gnt;
    assign route_on = (state == ST_ISSUE) || (state == ST_BUSY);

    always_comb begin
        tgt_ack     = '0;
        tgt_buff_wr = '0;
        sd_buff_din = 8'd0;
        for (int k = 0; k < N_TGT; k++) begin
            if (route_on && gnt == 3'(k)) begin
                tgt_ack[k]     = io_ack;
                tgt_buff_wr[k] = sd_buff_wr;
                sd_buff_din    = tgt_buff_din[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Randomized bench for scsi_io_arbiter against a transaction-level round-robin model.
module tb_scsi_io_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    tgt_rd, tgt_wr, tgt_ack, tgt_buff_wr;
    logic [32*N-1:0] tgt_lba;
    logic [8*N-1:0]  tgt_buff_din;
    logic [31:0]     io_lba;
    logic            io_rd, io_wr, io_ack, sd_buff_wr, timeout_err;
    logic [2:0]      io_sel;
    logic [7:0]      sd_buff_din;

    always #5 clk = ~clk;

    scsi_io_arbiter #(.N_TGT(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .tgt_rd(tgt_rd), .tgt_wr(tgt_wr), .tgt_lba(tgt_lba), .tgt_ack(tgt_ack),
        .tgt_buff_din(tgt_buff_din), .tgt_buff_wr(tgt_buff_wr),
        .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr), .io_ack(io_ack),
        .io_sel(io_sel), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .timeout_err(timeout_err)
    );

    int errs = 0;
    int checks = 0;

    // Target-side model: held requests, lba, buffer data, and the arbiter's fairness pointer.
    logic        m_rd [N];
    logic        m_wr [N];
    logic [31:0] m_lba [N];
    logic [7:0]  m_din [N];
    int          m_ptr;
    int          g;
    logic        cur_rd, cur_wr;
    logic [31:0] cur_lba;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            tgt_rd[i]              = m_rd[i];
            tgt_wr[i]              = m_wr[i];
            tgt_lba[32*i +: 32]    = m_lba[i];
            tgt_buff_din[8*i +: 8] = m_din[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (m_rd[i] || m_wr[i]) return i;
        end
        return -1;
    endfunction

    task automatic new_req(input int i);
        if (!m_rd[i] && !m_wr[i]) begin
            int d;
            d = int'($urandom_range(0, 2));
            m_rd[i]  = (d != 1);
            m_wr[i]  = (d != 0);
            m_lba[i] = $urandom;
        end
    endtask

    task automatic maybe_add();
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, 3) == 0) new_req(i);
    endtask

    task automatic rand_bus();
        for (int i = 0; i < N; i++) m_din[i] = 8'($urandom);
        sd_buff_wr = 1'($urandom);
    endtask

    task automatic wait_grant(input int exp_steps);
        int n;
        int e;
        n = 0;
        e = pick();
        if (e < 0) e = 0;
        do begin
            step();
            n++;
            if (!(io_rd || io_wr)) begin
                chk("idle_din", 32'(sd_buff_din), 32'd0);
                chk("idle_ack", 32'(tgt_ack), 32'd0);
            end
        end while (!(io_rd || io_wr) && n < 40);
        chk("grant_latency", n, exp_steps);
        g       = e;
        cur_rd  = m_rd[e];
        cur_wr  = !m_rd[e] && m_wr[e];
        cur_lba = m_lba[e];
        chk("io_sel", 32'(io_sel), g);
        chk("io_lba", io_lba, cur_lba);
        chk("io_rd", 32'(io_rd), 32'(cur_rd));
        chk("io_wr", 32'(io_wr), 32'(cur_wr));
    endtask

    task automatic xfer(input int ack_len, input bit tmo);
        if (tmo) begin
            io_ack = 1'b0;
            for (int w = 0; w < TO - 1; w++) begin
                maybe_add();
                drive();
                step();
                chk("issue_hold_rd", 32'(io_rd), 32'(cur_rd));
                chk("issue_hold_wr", 32'(io_wr), 32'(cur_wr));
            end
            step();
            chk("to_rd", 32'(io_rd), 32'd0);
            chk("to_wr", 32'(io_wr), 32'd0);
            chk("to_err", 32'(timeout_err), 32'd1);
            m_ptr = (g + 1) % N;
            wait_grant(1);
            chk("to_err_pulse", 32'(timeout_err), 32'd0);
        end else begin
            int wn;
            wn = int'($urandom_range(0, 4));
            for (int w = 0; w < wn; w++) begin
                io_ack = 1'b0;
                rand_bus();
                maybe_add();
                drive();
                #1;
                chk("issue_ack", 32'(tgt_ack), 32'd0);
                chk("issue_din", 32'(sd_buff_din), 32'(m_din[g]));
                chk("issue_bwr", 32'(tgt_buff_wr), 32'(sd_buff_wr) << g);
                step();
                chk("issue_rd", 32'(io_rd), 32'(cur_rd));
                chk("issue_wr", 32'(io_wr), 32'(cur_wr));
                chk("issue_terr", 32'(timeout_err), 32'd0);
            end
            for (int a = 0; a < ack_len; a++) begin
                io_ack = 1'b1;
                rand_bus();
                if (a == 0) begin
                    m_rd[g] = 1'b0;
                    m_wr[g] = 1'b0;
                end else begin
                    maybe_add();
                end
                if (a == ack_len - 1 && pick() < 0) new_req(int'($urandom_range(0, N - 1)));
                drive();
                #1;
                chk("ack_route", 32'(tgt_ack), 32'd1 << g);
                chk("bwr_route", 32'(tgt_buff_wr), 32'(sd_buff_wr) << g);
                chk("din_route", 32'(sd_buff_din), 32'(m_din[g]));
                step();
                chk("busy_rd", 32'(io_rd), 32'd0);
                chk("busy_wr", 32'(io_wr), 32'd0);
                chk("busy_sel", 32'(io_sel), g);
                chk("busy_lba", io_lba, cur_lba);
            end
            io_ack     = 1'b0;
            sd_buff_wr = 1'b0;
            m_ptr      = (g + 1) % N;
            wait_grant(3);
        end
    endtask

    initial begin
        rst = 1'b1;
        io_ack = 1'b0;
        sd_buff_wr = 1'b0;
        tgt_rd = '0;
        tgt_wr = '0;
        tgt_lba = '0;
        tgt_buff_din = '0;
        for (int i = 0; i < N; i++) begin
            m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_lba[i] = 32'd0; m_din[i] = 8'd0;
        end
        m_ptr = 0;
        g = 0;
        step();
        step();
        chk("rst_io_rd", 32'(io_rd), 32'd0);
        chk("rst_io_wr", 32'(io_wr), 32'd0);
        chk("rst_io_lba", io_lba, 32'd0);
        chk("rst_io_sel", 32'(io_sel), 32'd0);
        chk("rst_tgt_ack", 32'(tgt_ack), 32'd0);
        chk("rst_buff_wr", 32'(tgt_buff_wr), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_din", 32'(sd_buff_din), 32'd0);
        rst = 1'b0;

        // First transfer: target 0 reads lba 0x10, then a long buffer burst.
        m_rd[0]  = 1'b1;
        m_lba[0] = 32'h10;
        drive();
        wait_grant(1);
        xfer(3, 1'b0);
        xfer(512, 1'b0);

        for (int t = 0; t < 60; t++)
            xfer(int'($urandom_range(1, 6)), $urandom_range(0, 5) == 0);

        // Reset during BUSY with io_ack still high: nothing routed, grant waits for ack to drop.
        io_ack = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstb_io_rd", 32'(io_rd), 32'd0);
        chk("rstb_io_wr", 32'(io_wr), 32'd0);
        chk("rstb_tgt_ack", 32'(tgt_ack), 32'd0);
        for (int i = 0; i < N; i++) begin
            m_rd[i] = 1'b0; m_wr[i] = 1'b0;
        end
        m_ptr = 0;
        new_req(1);
        drive();
        for (int w = 0; w < 3; w++) begin
            step();
            chk("stale_rd", 32'(io_rd | io_wr), 32'd0);
            chk("stale_ack", 32'(tgt_ack), 32'd0);
        end
        io_ack = 1'b0;
        wait_grant(1);
        xfer(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
